// File: rtl/udp_encoder_pkg.sv
// Shared UDP definitions: protocol number, header size, FSM encoding and
// the tail-byte mask used when padding the last payload word.
package udp_encoder_pkg;

    localparam logic [7:0]  UDP_PROTO     = 8'h11;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        HDR1,
        HDR2,
        SEND,
        FIN
    } udp_state_t;

    // tail = payload_len[1:0]; zero means the final word is fully populated
    function automatic logic [31:0] tail_mask(input logic [1:0] tail);
        case (tail)
            2'd1:    tail_mask = 32'hFF00_0000;
            2'd2:    tail_mask = 32'hFFFF_0000;
            2'd3:    tail_mask = 32'hFFFF_FF00;
            default: tail_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/one_complement_adder.sv
// Ones-complement adder: binary add with the carry-out wrapped back into bit 0.
module one_complement_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    // a single wrap suffices: with a carry, the low part is at most 2^W-2
    assign sum = raw[W-1:0] + {{(W-1){1'b0}}, raw[W]};

endmodule

// File: rtl/udp_payload_buffer.sv
// Simple dual-port payload RAM: one write port, one synchronous read port.
module udp_payload_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[rd_addr];
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/udp_encoder.sv
// UDP transmit encoder: buffers the payload while summing the checksum,
// then streams the 8-byte header followed by the payload words.
module udp_encoder
    import udp_encoder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dest_ip,
    input  logic [31:0] src_ip,
    input  logic [15:0] dest_port,
    input  logic [15:0] src_port,
    input  logic [15:0] payload_len,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    output logic [31:0] data_out,
    output logic        wr_en,
    output logic        fin,
    output logic        err
);

    localparam logic [16:0] MAX_LEN = 17'(4 * DEPTH);
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    udp_state_t  state_reg;
    logic [AW:0] wcnt_reg;
    logic [AW:0] rcnt_reg;
    logic [AW:0] nwords_reg;
    logic [1:0]  tail_reg;
    logic [15:0] udp_len_reg;
    logic [15:0] src_port_reg;
    logic [15:0] dest_port_reg;
    logic [31:0] acc_reg;
    logic [15:0] csum_reg;
    logic [31:0] data_out_reg;
    logic        wr_en_reg;
    logic        fin_reg;
    logic        err_reg;

    logic [15:0] udp_len_in;
    logic [AW:0] nwords_in;
    logic        oversize;
    logic [31:0] sum_a;
    logic [31:0] sum_b;
    logic [31:0] sum_c;
    logic [31:0] init_sum;
    logic        last_word;
    logic        last_send;
    logic [31:0] masked_word;
    logic [31:0] load_sum;
    logic [15:0] folded;
    logic [15:0] csum_inv;
    logic [15:0] csum_next;
    logic [AW-1:0] rd_addr;
    logic [31:0] rd_data;
    logic        buf_we;

    assign udp_len_in = payload_len + UDP_HDR_BYTES;
    assign oversize   = {1'b0, payload_len} > MAX_LEN;
    // ceil(len/4); the truncated width is exact once oversize lengths are rejected
    assign nwords_in  = payload_len[AW+2:2] + {{AW{1'b0}}, |payload_len[1:0]};

    // Pseudo-header plus UDP header, checksum field taken as zero
    one_complement_adder #(.W(32)) u_init_a (
        .a(src_ip), .b(dest_ip), .sum(sum_a)
    );
    one_complement_adder #(.W(32)) u_init_b (
        .a(sum_a), .b({8'd0, UDP_PROTO, udp_len_in}), .sum(sum_b)
    );
    one_complement_adder #(.W(32)) u_init_c (
        .a(sum_b), .b({src_port, dest_port}), .sum(sum_c)
    );
    one_complement_adder #(.W(32)) u_init_d (
        .a(sum_c), .b({udp_len_in, 16'h0000}), .sum(init_sum)
    );

    assign last_word   = (wcnt_reg == nwords_reg - CNT_ONE);
    assign last_send   = (rcnt_reg == nwords_reg - CNT_ONE);
    assign masked_word = last_word ? (data_in & tail_mask(tail_reg)) : data_in;

    // Adding the whole word is the same as adding both halves once folded
    one_complement_adder #(.W(32)) u_load (
        .a(acc_reg), .b(masked_word), .sum(load_sum)
    );
    one_complement_adder #(.W(16)) u_fold (
        .a(acc_reg[31:16]), .b(acc_reg[15:0]), .sum(folded)
    );

    assign csum_inv  = ~folded;
    assign csum_next = (csum_inv == 16'h0000) ? 16'hFFFF : csum_inv;

    // Address runs one word ahead of the output so SEND has no bubbles
    assign rd_addr = (state_reg == SEND) ? (rcnt_reg[AW-1:0] + {{(AW-1){1'b0}}, 1'b1})
                                         : {AW{1'b0}};
    assign buf_we  = (state_reg == LOAD) && data_in_valid;

    udp_payload_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wcnt_reg[AW-1:0]),
        .wr_data (masked_word),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wcnt_reg      <= '0;
            rcnt_reg      <= '0;
            nwords_reg    <= '0;
            tail_reg      <= '0;
            udp_len_reg   <= '0;
            src_port_reg  <= '0;
            dest_port_reg <= '0;
            acc_reg       <= '0;
            csum_reg      <= '0;
            data_out_reg  <= '0;
            wr_en_reg     <= 1'b0;
            fin_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            data_out_reg <= '0;
            wr_en_reg    <= 1'b0;
            fin_reg      <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (oversize) begin
                            err_reg <= 1'b1;
                        end else begin
                            src_port_reg  <= src_port;
                            dest_port_reg <= dest_port;
                            udp_len_reg   <= udp_len_in;
                            tail_reg      <= payload_len[1:0];
                            nwords_reg    <= nwords_in;
                            acc_reg       <= init_sum;
                            wcnt_reg      <= '0;
                            rcnt_reg      <= '0;
                            state_reg     <= (nwords_in == '0) ? CSUM : LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (data_in_valid) begin
                        acc_reg  <= load_sum;
                        wcnt_reg <= wcnt_reg + CNT_ONE;
                        if (last_word) begin
                            state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    csum_reg  <= csum_next;
                    rcnt_reg  <= '0;
                    state_reg <= HDR1;
                end
                HDR1: begin
                    wr_en_reg    <= 1'b1;
                    data_out_reg <= {src_port_reg, dest_port_reg};
                    state_reg    <= HDR2;
                end
                HDR2: begin
                    wr_en_reg    <= 1'b1;
                    data_out_reg <= {udp_len_reg, csum_reg};
                    state_reg    <= (nwords_reg == '0) ? FIN : SEND;
                end
                SEND: begin
                    wr_en_reg    <= 1'b1;
                    data_out_reg <= rd_data;
                    rcnt_reg     <= rcnt_reg + CNT_ONE;
                    if (last_send) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    fin_reg   <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign data_in_ready = (state_reg == LOAD);
    assign data_out      = data_out_reg;
    assign wr_en         = wr_en_reg;
    assign fin           = fin_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_udp_encoder.sv
// Directed bench for udp_encoder: header/checksum vectors, padding, empty and
// oversize datagrams, stalls, back-to-back starts and mid-datagram reset.
module tb_udp_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dest_ip = '0;
    logic [31:0] src_ip = '0;
    logic [15:0] dest_port = '0;
    logic [15:0] src_port = '0;
    logic [15:0] payload_len = '0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic        wr_en;
    logic        fin;
    logic        err;

    udp_encoder #(.DEPTH(64), .AW(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dest_ip       (dest_ip),
        .src_ip        (src_ip),
        .dest_port     (dest_port),
        .src_port      (src_port),
        .payload_len   (payload_len),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .wr_en         (wr_en),
        .fin           (fin),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fin_cnt = 0;
    int err_cnt = 0;
    int fin_cyc = 0;
    bit ready_seen = 0;
    logic [31:0] outq[$];
    int          outcyc[$];
    logic [31:0] wbuf [64];
    logic [31:0] exp_w [66];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            outq.push_back(data_out);
            outcyc.push_back(cyc);
        end
        if (fin) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (err) err_cnt++;
        if (data_in_ready) ready_seen = 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        outq.delete();
        outcyc.delete();
        fin_cnt = 0;
        err_cnt = 0;
        ready_seen = 0;
    endtask

    task automatic set_fields();
        src_ip    = 32'h0A00_0001;
        dest_ip   = 32'h0A00_0002;
        src_port  = 16'h1234;
        dest_port = 16'h5678;
    endtask

    // Ones-complement checksum over 16-bit fields, payload assumed pre-padded
    function automatic logic [15:0] model_csum(input logic [15:0] len, input int n);
        int unsigned s;
        logic [15:0] r;
        s = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dest_ip[31:16]) + 32'(dest_ip[15:0])
          + 32'h11 + 2 * (32'(len) + 8) + 32'(src_port) + 32'(dest_port);
        for (int i = 0; i < n; i++) s += 32'(wbuf[i][31:16]) + 32'(wbuf[i][15:0]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        r = ~s[15:0];
        return (r == 16'h0000) ? 16'hFFFF : r;
    endfunction

    task automatic send(input logic [15:0] len, input int n, input bit stall);
        int idx = 0;
        int guard = 0;
        bit rdy;
        bit vld;
        @(posedge clk); #1;
        payload_len = len;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && guard < 3000) begin
            vld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in_valid = vld;
            data_in = wbuf[idx];
            rdy = data_in_ready;
            @(posedge clk); #1;
            if (vld && rdy) idx++;
            guard++;
        end
        data_in_valid = 1'b0;
        checks++;
        if (idx !== n) begin
            errors++;
            $display("FAIL load_accept got %0d want %0d words", idx, n);
        end
    endtask

    task automatic wait_fin();
        int g = 0;
        while (!fin && g < 500) begin
            @(negedge clk);
            g++;
        end
        #1;
        checks++;
        if (fin_cnt !== 1) begin
            errors++;
            $display("FAIL fin_count got %0d want 1", fin_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_fin got %b want 0", fin); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
        checks++; if (data_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", data_in_ready); end
        reset = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic();
        clear_mon();
        set_fields();
        wbuf[0] = 32'hDEAD_BEEF;
        send(16'd4, 1, 1'b0);
        wait_fin();
        exp_w[0] = 32'h1234_5678; exp_w[1] = 32'h000C_E589; exp_w[2] = 32'hDEAD_BEEF;
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL basic_len got %0d want 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, outq[i], exp_w[i]); end
        end
        if (outq.size() == 3) begin
            checks++; if (outcyc[0] - start_cyc !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", outcyc[0] - start_cyc); end
            checks++; if (outcyc[2] - outcyc[0] !== 2) begin errors++; $display("FAIL basic_gapless got %0d want 2", outcyc[2] - outcyc[0]); end
            checks++; if (fin_cyc - outcyc[2] !== 1) begin errors++; $display("FAIL basic_fin_pos got %0d want 1", fin_cyc - outcyc[2]); end
        end
        $display("basic: len=4 words=%0d", outq.size());
    endtask

    task automatic test_zero_csum();
        clear_mon();
        set_fields();
        wbuf[0] = 32'h8327_0000;
        send(16'd4, 1, 1'b0);
        wait_fin();
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL zcsum_len got %0d want 3", outq.size()); end
        if (outq.size() == 3) begin
            checks++; if (outq[1] !== 32'h000C_FFFF) begin errors++; $display("FAIL zcsum_hdr2 got %h want 000cffff", outq[1]); end
            checks++; if (outq[2] !== 32'h8327_0000) begin errors++; $display("FAIL zcsum_payload got %h want 83270000", outq[2]); end
        end
        $display("zero_csum: words=%0d", outq.size());
    endtask

    task automatic test_padding();
        clear_mon();
        set_fields();
        wbuf[0] = 32'hAB12_3456;
        send(16'd1, 1, 1'b0);
        wait_fin();
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL pad_len got %0d want 3", outq.size()); end
        if (outq.size() == 3) begin
            checks++; if (outq[1] !== 32'h0009_D82C) begin errors++; $display("FAIL pad_hdr2 got %h want 0009d82c", outq[1]); end
            checks++; if (outq[2] !== 32'hAB00_0000) begin errors++; $display("FAIL pad_payload got %h want ab000000", outq[2]); end
        end
        $display("padding: len=1 words=%0d", outq.size());
    endtask

    task automatic test_empty();
        clear_mon();
        set_fields();
        send(16'd0, 0, 1'b0);
        wait_fin();
        checks++; if (outq.size() !== 2) begin errors++; $display("FAIL empty_len got %0d want 2", outq.size()); end
        if (outq.size() == 2) begin
            checks++; if (outq[0] !== 32'h1234_5678) begin errors++; $display("FAIL empty_hdr1 got %h want 12345678", outq[0]); end
            checks++; if (outq[1] !== 32'h0008_832F) begin errors++; $display("FAIL empty_hdr2 got %h want 0008832f", outq[1]); end
            checks++; if (outcyc[0] - start_cyc !== 2) begin errors++; $display("FAIL empty_latency got %0d want 2", outcyc[0] - start_cyc); end
        end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL empty_ready got %b want 0", ready_seen); end
        $display("empty: words=%0d", outq.size());
    endtask

    task automatic test_oversize();
        clear_mon();
        set_fields();
        @(posedge clk); #1;
        payload_len = 16'd257;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL over_err got %0d want 1 cycle", err_cnt); end
        checks++; if (outq.size() !== 0) begin errors++; $display("FAIL over_wr_en got %0d want 0 words", outq.size()); end
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL over_idle got ready %b want 0", ready_seen); end
        checks++; if (fin_cnt !== 0) begin errors++; $display("FAIL over_fin got %0d want 0", fin_cnt); end
        $display("oversize: len=257 err_cycles=%0d", err_cnt);
    endtask

    task automatic test_max_len();
        logic [15:0] cs;
        clear_mon();
        set_fields();
        for (int i = 0; i < 64; i++) wbuf[i] = 32'h0100_0000 * i + 32'h0000_5A5A + i;
        cs = model_csum(16'd256, 64);
        exp_w[0] = 32'h1234_5678;
        exp_w[1] = {16'd264, cs};
        for (int i = 0; i < 64; i++) exp_w[i + 2] = wbuf[i];
        send(16'd256, 64, 1'b0);
        wait_fin();
        checks++; if (outq.size() !== 66) begin errors++; $display("FAIL max_len got %0d want 66", outq.size()); end
        for (int i = 0; i < 66 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== exp_w[i]) begin errors++; $display("FAIL max_word%0d got %h want %h", i, outq[i], exp_w[i]); end
        end
        $display("max_len: len=256 words=%0d", outq.size());
    endtask

    task automatic test_back_to_back();
        logic [15:0] cs;
        clear_mon();
        set_fields();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hA500_0000 ^ (i * 32'h0103_0507);
        cs = model_csum(16'd64, 16);
        exp_w[0] = 32'h1234_5678;
        exp_w[1] = {16'd72, cs};
        for (int i = 0; i < 16; i++) exp_w[i + 2] = wbuf[i];
        send(16'd64, 16, 1'b1);
        wait_fin();
        checks++; if (outq.size() !== 18) begin errors++; $display("FAIL stall_len got %0d want 18", outq.size()); end
        for (int i = 0; i < 18 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== exp_w[i]) begin errors++; $display("FAIL stall_word%0d got %h want %h", i, outq[i], exp_w[i]); end
        end
        $display("stall: words=%0d hdr2=%h", outq.size(), exp_w[1]);
        clear_mon();
        send(16'd64, 16, 1'b0);
        wait_fin();
        checks++; if (outq.size() !== 18) begin errors++; $display("FAIL b2b_len got %0d want 18", outq.size()); end
        for (int i = 0; i < 18 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, outq[i], exp_w[i]); end
        end
        if (outq.size() > 0) begin
            checks++; if (outcyc[0] - start_cyc !== 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", outcyc[0] - start_cyc); end
        end
        $display("back_to_back: words=%0d", outq.size());
    endtask

    task automatic test_reset_mid();
        int g = 0;
        int n_at;
        clear_mon();
        set_fields();
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h1111_0000 + i;
        send(16'd64, 16, 1'b0);
        while (outq.size() < 5 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en got %b want 0", wr_en); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL midrst_fin got %b want 0", fin); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 0", data_out); end
        reset = 1'b1;
        n_at = outq.size();
        repeat (24) @(posedge clk);
        #1;
        checks++; if (fin_cnt !== 0) begin errors++; $display("FAIL midrst_nofin got %0d want 0", fin_cnt); end
        checks++; if (outq.size() !== n_at) begin errors++; $display("FAIL midrst_quiet got %0d want %0d words", outq.size(), n_at); end
        $display("reset_mid: aborted after %0d words", n_at);
        clear_mon();
        wbuf[0] = 32'hDEAD_BEEF;
        send(16'd4, 1, 1'b0);
        wait_fin();
        exp_w[0] = 32'h1234_5678; exp_w[1] = 32'h000C_E589; exp_w[2] = 32'hDEAD_BEEF;
        checks++; if (outq.size() !== 3) begin errors++; $display("FAIL postrst_len got %0d want 3", outq.size()); end
        for (int i = 0; i < 3 && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== exp_w[i]) begin errors++; $display("FAIL postrst_word%0d got %h want %h", i, outq[i], exp_w[i]); end
        end
        $display("post_reset: words=%0d", outq.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_csum();
        test_padding();
        test_empty();
        test_oversize();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
